// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO of {instr, pc+4}; entries reach decode one edge after the push.
// in_ready depends only on occupancy and reset; flush empties the queue and outranks push/pop.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_instr,
  output logic [WIDTH-1:0]         out_pc,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              bubbles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [15:0]        r_bubbles;

  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_head;

  assign in_ready  = rst && (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  // A flush cycle neither writes nor retires, even if the handshakes look complete.
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_instr = out_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign out_pc    = out_valid ? w_head[WIDTH-1:0]       : '0;
  assign count     = r_count;
  assign bubbles   = r_bubbles;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_instr, in_pc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubbles <= '0;
    end else if (out_ready && !out_valid && !flush && (r_bubbles != 16'hFFFF)) begin
      r_bubbles <= r_bubbles + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_instr;
  logic [WIDTH-1:0]  in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_instr;
  logic [WIDTH-1:0]  out_pc;
  logic              flush;
  logic [1:0]        count;
  logic [15:0]       bubbles;

  int checks = 0;
  int errors = 0;

  logic [2*WIDTH-1:0] mq[$];
  int                 mbub;
  bit                 log_pops;
  logic [WIDTH-1:0]   popped[$];

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .flush(flush), .count(count), .bubbles(bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model advances on each edge from the inputs the DUT sampled.
  task automatic model_update();
    bit m_push, m_pop;
    if (!rst) return;
    m_push = in_valid && (mq.size() < DEPTH);
    m_pop  = out_ready && (mq.size() > 0);
    if (out_ready && mq.size() == 0 && !flush && mbub < 65535) mbub++;
    if (flush) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_instr, in_pc});
    end
  endtask

  task automatic compare_all();
    logic [2*WIDTH-1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("in_ready",  32'(in_ready),  32'(rst && (mq.size() < DEPTH)));
    check("count",     32'(count),     32'(mq.size()));
    check("out_instr", out_instr,      head[2*WIDTH-1:WIDTH]);
    check("out_pc",    out_pc,         head[WIDTH-1:0]);
    check("bubbles",   32'(bubbles),   32'(mbub[15:0]));
  endtask

  task automatic step();
    if (log_pops && out_valid && out_ready && !flush) popped.push_back(out_instr);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0; mbub = 0; log_pops = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_out_valid",32'(out_valid),32'd0);
    check("rst_out_instr",out_instr,     32'd0);
    check("rst_bubbles",  32'(bubbles),  32'd0);
    rst = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);

    // Starved decode for 5 cycles, one of them a flush: 4 bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      step();
    end
    flush = 1'b0;
    check("bubbles_4", 32'(bubbles), 32'd4);

    out_ready = 1'b0;
    push(32'h20080005, 32'd4);
    push(32'h20090007, 32'd8);
    check("fill_count",    32'(count),    32'd2);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_instr",    out_instr,     32'h20080005);
    check("fill_pc",       out_pc,        32'd4);

    // Drain a full queue while fetch holds a third word.
    out_ready = 1'b1; log_pops = 1'b1;
    in_valid = 1'b1; in_instr = 32'h01095020; in_pc = 32'd12;
    for (int i = 0; i < 5; i++) begin
      bit acc;
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    log_pops = 1'b0;
    check("pop_total", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      check("pop0", popped[0], 32'h20080005);
      check("pop1", popped[1], 32'h20090007);
      check("pop2", popped[2], 32'h01095020);
    end

    // Push and pop together at count=1; the pointers wrap several times.
    out_ready = 1'b0;
    push(32'h1000_0000, 32'd4);
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; in_instr = 32'h1000_0000 + k; in_pc = 32'(4 + 4 * k);
      step();
      check("stream_count", 32'(count), 32'd1);
      check("stream_pc",    out_pc,     32'(4 + 4 * k));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    push(32'h2000_0001, 32'd100);
    check("preflush_count", 32'(count), 32'd2);
    flush = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 32'd200;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_instr", out_instr,      32'd0);
    step();
    check("flush_word_dropped", 32'(out_valid), 32'd0);
    push(32'h3000_0003, 32'd300);
    check("post_flush_push", out_instr, 32'h3000_0003);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      step();
    end
    flush = 1'b0;

    // Asynchronous reset between edges.
    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h4444_0000; in_pc = 32'd44;
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_count",    32'(count),     32'd0);
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_bubbles",  32'(bubbles),   32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd0);
    mq.delete(); mbub = 0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check("arst_release", 32'(in_ready), 32'd1);

    // Saturation of the starvation counter.
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (65540) step();
    check("bubbles_sat", 32'(bubbles), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
